muldiv_ctrl: RTL
================

# muldiv_ctrl

Multi-cycle divide sequencer and pipeline stall controller for the five-stage core. It runs a 32-iteration restoring divider for DIV/DIVU issued from EX and returns {remainder, quotient} for the HI/LO write path. While a divide is in flight it holds the front of the pipeline and lets the MEM/WB side drain. It also merges the ID-stage stall request into the single stall vector consumed by PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

## Interface
Parameters:
- DATA_W, 32, operand width; iteration count equals DATA_W.

Ports:
- clk  input  1  core clock
- rst  input  1  reset; synchronous, active-high (`RstEnable` = 1'b1), sampled on posedge clk
- stallreq_id  input  1  load-use / operand hazard stall request from ID
- div_start  input  1  EX holds a DIV/DIVU; level, held high until result accepted
- div_signed  input  1  1 = DIV (two's complement), 0 = DIVU
- div_opdata1  input  DATA_W  dividend (rs)
- div_opdata2  input  DATA_W  divisor (rt)
- div_annul  input  1  cancel in-flight divide (exception/flush)
- div_result  output  2*DATA_W  {remainder, quotient}; remainder → HI, quotient → LO
- div_ready  output  1  div_result valid this cycle
- stall  output  6  bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB

## Operation
- States: IDLE, BYZERO, ON, END. Registers: state, cnt[5:0], dividend shift register {rem_acc, quot}, |divisor|, sign flags. All of these, div_result and div_ready reset to IDLE / 0.
- IDLE:
  - div_start=1 and div_annul=0 and divisor==0 → BYZERO.
  - div_start=1 and div_annul=0 and divisor≠0 → ON. Latch |dividend| and |divisor| (magnitude only when div_signed). Latch q_neg = sign1^sign2 and r_neg = sign1. Clear cnt.
  - Otherwise stay in IDLE with div_ready=0.
- BYZERO: next edge → END with div_result = 0.
- ON:
  - Each edge while cnt<32: shift {rem_acc, quot} left 1 and trial-subtract |divisor| from rem_acc. On no borrow, keep the difference and set quotient LSB to 1. cnt++.
  - Edge with cnt==32: apply sign fix (quotient negated if q_neg, remainder negated if r_neg, DIV only), load div_result, → END.
  - div_annul=1 at any edge in ON → IDLE. Partial result is discarded and div_ready stays 0.
- END: div_ready=1 and div_result stable. div_start=0 → IDLE with div_ready cleared at the same edge. div_start still 1 → stay in END.
- Arithmetic: 32-bit subtraction on a 33-bit trial value. Signed 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0, with no trap.
- Stall vector (combinational from current state and inputs):
  - stallreq_ex = div_start & ~div_ready.
  - rst=1 → 6'b000000.
  - stallreq_ex → 6'b001111 (PC, IF/ID, ID/EX, EX/MEM held; MEM/WB and WB drain; EX/MEM inserts a bubble).
  - else stallreq_id → 6'b000111.
  - else 6'b000000.
  - EX request has priority over ID when both are asserted.

## Timing
- Start sampled at edge E (IDLE→ON). Iterations run on edges E+1…E+32, result and END on edge E+33. div_ready is high from after E+33. stall=001111 from the cycle div_start rises until div_ready rises.
- Divide by zero: IDLE→BYZERO at E, END at E+1. div_ready is high after E+1.
- Release: EX drops div_start in the cycle after div_ready is seen. div_ready falls on the following edge, so no second start is sampled from the same instruction.
- Annul and start together in IDLE: annul wins, no launch.
- Reset mid-operation (any state): next edge returns IDLE, div_ready=0, div_result=0, cnt=0. stall is 0 while rst=1.
- Back-to-back divides: a new start is sampled only in IDLE, at least one cycle after END.

## Test plan
- DIVU 100/7, start at E: stall=001111 until ready. div_ready rises after E+33 with div_result = {0x00000002, 0x0000000E}; stall returns to 000000.
- DIV 0xFFFFFFF9 (−7) / 2: result {0xFFFFFFFF, 0xFFFFFFFD}. DIV 0x80000000 / 0xFFFFFFFF: result {0x00000000, 0x80000000}.
- DIVU 5/0: BYZERO path; div_ready after E+1 with result 0; stall=001111 for exactly 2 cycles.
- Start a divide, assert div_annul for 1 cycle at iteration 10, then deassert div_start: state IDLE, div_ready never asserts, stall drops the cycle div_start falls.
- stallreq_id=1 alone → stall=000111. stallreq_id=1 during a divide → stall=001111.
- Assert rst for 1 cycle at iteration 20, then relaunch DIVU 0xFFFFFFFF/0x10: result {0x0000000F, 0x0FFFFFFF} 34 edges after relaunch.

Source files
------------

// File: rtl/muldiv_if.sv
// Handshake bundle between the EX-stage divide issue logic and the divide/stall controller.
// The master side is the pipeline (EX/ID); the slave side is muldiv_ctrl.
interface muldiv_if #(
    parameter int DATA_W = 32
);
    logic                  stallreq_id;
    logic                  div_start;
    logic                  div_signed;
    logic [DATA_W-1:0]     div_opdata1;
    logic [DATA_W-1:0]     div_opdata2;
    logic                  div_annul;
    logic [2*DATA_W-1:0]   div_result;
    logic                  div_ready;
    logic [5:0]            stall;

    modport master (
        output stallreq_id, div_start, div_signed, div_opdata1, div_opdata2, div_annul,
        input  div_result, div_ready, stall
    );

    modport slave (
        input  stallreq_id, div_start, div_signed, div_opdata1, div_opdata2, div_annul,
        output div_result, div_ready, stall
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Restoring divide sequencer (DIV/DIVU, one quotient bit per cycle) and the merged
// pipeline stall vector for PC, IF/ID, ID/EX, EX/MEM, MEM/WB and WB.
module muldiv_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic      clk,
    input  logic      rst,
    muldiv_if.slave   bus
);
    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] ITER = CNT_W'(DATA_W);

    typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_W-1:0]     rem_acc;
    logic [DATA_W-1:0]     quot;
    logic [DATA_W-1:0]     divisor;
    logic                  q_neg;
    logic                  r_neg;
    logic [2*DATA_W-1:0]   result;
    logic                  ready;
    logic                  launch;
    logic [DATA_W:0]       partial;
    logic [DATA_W+1:0]     diff;
    logic                  borrow;
    logic                  stallreq_ex;
    logic [5:0]            stall_vec;

    // Absolute value for signed operands; the most negative value maps onto itself,
    // which is still the correct unsigned magnitude.
    function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                    input logic is_signed);
        logic signed [DATA_W-1:0] neg;
        neg = -v;
        return (is_signed && v[DATA_W-1]) ? $unsigned(neg) : $unsigned(v);
    endfunction

    function automatic logic [DATA_W-1:0] sign_fix(input logic [DATA_W-1:0] v,
                                                   input logic negate);
        logic signed [DATA_W-1:0] sv;
        sv = $signed(v);
        return negate ? $unsigned(-sv) : v;
    endfunction

    assign launch = bus.div_start && !bus.div_annul;

    // The bit shifted out of rem_acc is kept as the 33rd trial bit so divisors above
    // 2^(DATA_W-1) still divide correctly.
    always_comb begin
        partial = {rem_acc, quot[DATA_W-1]};
        diff    = {1'b0, partial} - {2'b00, divisor};
        borrow  = diff[DATA_W+1];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch) state_nxt = (bus.div_opdata2 == '0) ? BYZERO : ON;
            BYZERO:  state_nxt = END;
            ON: begin
                if (bus.div_annul)     state_nxt = IDLE;
                else if (cnt == ITER)  state_nxt = END;
            end
            END:     if (!bus.div_start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rem_acc <= '0;
            quot    <= '0;
            divisor <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            result  <= '0;
            ready   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    ready <= 1'b0;
                    if (launch) begin
                        rem_acc <= '0;
                        quot    <= magnitude(bus.div_opdata1, bus.div_signed);
                        divisor <= magnitude(bus.div_opdata2, bus.div_signed);
                        q_neg   <= bus.div_signed & (bus.div_opdata1[DATA_W-1] ^ bus.div_opdata2[DATA_W-1]);
                        r_neg   <= bus.div_signed & bus.div_opdata1[DATA_W-1];
                        cnt     <= '0;
                    end
                end
                BYZERO: begin
                    result <= '0;
                    ready  <= 1'b1;
                end
                ON: begin
                    if (!bus.div_annul) begin
                        if (cnt != ITER) begin
                            rem_acc <= borrow ? partial[DATA_W-1:0] : diff[DATA_W-1:0];
                            quot    <= {quot[DATA_W-2:0], ~borrow};
                            cnt     <= cnt + 1'b1;
                        end else begin
                            result <= {sign_fix(rem_acc, r_neg), sign_fix(quot, q_neg)};
                            ready  <= 1'b1;
                        end
                    end
                end
                END: if (!bus.div_start) ready <= 1'b0;
                default: ready <= 1'b0;
            endcase
        end
    end

    // EX stall holds everything up to EX/MEM; MEM/WB and WB keep draining.
    assign stallreq_ex = bus.div_start & ~ready;

    always_comb begin
        stall_vec = 6'b000000;
        if (rst)                  stall_vec = 6'b000000;
        else if (stallreq_ex)     stall_vec = 6'b001111;
        else if (bus.stallreq_id) stall_vec = 6'b000111;
    end

    assign bus.div_result = result;
    assign bus.div_ready  = ready;
    assign bus.stall      = stall_vec;
endmodule
